// File: rtl/crc16_pkg.sv
// crc16_pkg: shared CRC-16 widths, generator polynomial and FSM states
package crc16_pkg;
  localparam int MSG_W = 23;
  localparam int CRC_W = 16;
  localparam int CW_W = MSG_W + CRC_W;
  localparam logic [CRC_W-1:0] POLY = 16'h8005;
  typedef enum logic {IDLE, RECV} state_t;
endpackage

// File: rtl/crc16_serial_divider.sv
// crc16_serial_divider: bit-serial polynomial division remainder register
module crc16_serial_divider
  import crc16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             bit_in,
  output logic [CRC_W-1:0] rem,
  output logic [CRC_W-1:0] rem_next
);
  // start divides from a zero remainder, so its leading bit never feeds back
  always_comb rem_next = start ? {{(CRC_W-1){1'b0}}, bit_in}
                       : step  ? ({rem[CRC_W-2:0], bit_in} ^ (rem[CRC_W-1] ? POLY : '0))
                       : rem;
  // remainder register
  always_ff @(posedge clk) rem <= !rst_n ? '0 : rem_next;
endmodule

// File: rtl/crc16_serial_receiver.sv
// crc16_serial_receiver: serial CRC-16 codeword receiver with frame check
module crc16_serial_receiver
  import crc16_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 sof,
  output logic [MSG_W-1:0]     msg_out,
  output logic [CRC_W-1:0]     syndrome,
  output logic                 crc_ok,
  output logic                 out_valid,
  output logic                 frame_abort,
  output logic [ERR_CNT_W-1:0] err_count
);
  state_t state, state_next;
  logic [5:0] cnt;
  logic [MSG_W-1:0] msg_sr;
  logic [CRC_W-1:0] rem, rem_next;
  logic start, step, done;
  crc16_serial_divider u_div (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .bit_in(bit_in),
    .rem(rem), .rem_next(rem_next)
  );
  // sof always restarts a frame, even on what would be the last bit
  always_comb begin
    start = bit_valid & sof;
    step = bit_valid & ~sof & (state == RECV);
    done = step & (cnt == 6'(CW_W - 1));
    state_next = start ? RECV : done ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_next;
  // bit counter, message capture and registered frame results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {cnt, msg_sr, msg_out, syndrome, crc_ok, out_valid, frame_abort, err_count} <= '0;
    end else begin
      out_valid <= done;
      frame_abort <= start & (state == RECV);
      if (start) begin
        cnt <= 6'd1;
        msg_sr <= {{(MSG_W-1){1'b0}}, bit_in};
      end else if (step) begin
        cnt <= cnt + 6'd1;
        if (cnt < 6'(MSG_W)) msg_sr <= {msg_sr[MSG_W-2:0], bit_in};
      end
      if (done) begin
        msg_out <= msg_sr;
        syndrome <= rem_next;
        crc_ok <= rem_next == '0;
        if (rem_next != '0 && !(&err_count)) err_count <= err_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_crc16_serial_receiver.sv
// tb_crc16_serial_receiver: directed self-checking bench for the CRC-16 receiver
module tb_crc16_serial_receiver;
  logic clk = 0, rst_n = 0, bit_in = 0, bit_valid = 0, sof = 0;
  logic [22:0] msg_out;
  logic [15:0] syndrome;
  logic crc_ok, out_valid, frame_abort;
  logic [7:0] err_count;
  int total = 0, passed = 0, ov_cnt = 0, ab_cnt = 0, n0 = 0, a0 = 0;
  localparam logic [38:0] F0 = 39'h0;
  localparam logic [38:0] F1 = {23'h000001, 16'h8005};
  localparam logic [38:0] F2 = {23'h000002, 16'h800F};
  localparam logic [38:0] FB = {23'h000001, 16'h8004};

  crc16_serial_receiver dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .msg_out(msg_out), .syndrome(syndrome), .crc_ok(crc_ok), .out_valid(out_valid),
    .frame_abort(frame_abort), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) ov_cnt++;
    if (frame_abort) ab_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_result(input string tag, input logic [22:0] m, input logic [15:0] s,
                              input logic ok, input logic [7:0] e);
    check({tag, " out_valid"}, 64'(out_valid), 64'd1);
    check({tag, " msg_out"}, 64'(msg_out), 64'(m));
    check({tag, " syndrome"}, 64'(syndrome), 64'(s));
    check({tag, " crc_ok"}, 64'(crc_ok), 64'(ok));
    check({tag, " err_count"}, 64'(err_count), 64'(e));
  endtask

  task automatic send_bit(input logic b, input logic s, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bit_in = b;
    sof = s;
    bit_valid = 1;
    @(posedge clk);
    #1;
    bit_valid = 0;
    sof = 0;
  endtask

  task automatic send_bits(input logic [38:0] cw, input int hi, input int lo,
                           input bit s_first, input bit gaps);
    for (int i = hi; i >= lo; i--)
      send_bit(cw[i], s_first && i == hi, gaps ? int'($urandom_range(0, 5)) : 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", 64'({msg_out, syndrome, crc_ok, out_valid, frame_abort, err_count}), 64'd0);
    rst_n = 1;
    send_bits(F0, 38, 0, 1, 0);
    check_result("zero frame", 23'h0, 16'h0, 1'b1, 8'd0);
    send_bits(F1, 38, 0, 1, 0);
    check_result("msg1", 23'h1, 16'h0, 1'b1, 8'd0);
    send_bits(F2, 38, 0, 1, 0);
    check_result("msg2", 23'h2, 16'h0, 1'b1, 8'd0);
    send_bits(FB, 38, 0, 1, 0);
    check_result("msg1 bad lsb", 23'h1, 16'h0001, 1'b0, 8'd1);
    @(posedge clk);
    #1;
    check("out_valid one cycle", 64'(out_valid), 64'd0);
    check("results held", 64'({msg_out, syndrome, crc_ok}), 64'({23'h1, 16'h0001, 1'b0}));
    n0 = ov_cnt;
    send_bits(F2, 38, 0, 1, 1);
    check_result("msg2 gaps", 23'h2, 16'h0, 1'b1, 8'd1);
    @(posedge clk);
    #1;
    check("gaps single out_valid", 64'(ov_cnt - n0), 64'd1);
    n0 = ov_cnt;
    a0 = ab_cnt;
    send_bits(FB, 38, 19, 1, 0);
    send_bits(F1, 38, 38, 1, 0);
    check("abort20 pulse", 64'(frame_abort), 64'd1);
    check("abort20 held", 64'({msg_out, syndrome, crc_ok, out_valid, err_count}),
          64'({23'h2, 16'h0, 1'b1, 1'b0, 8'd1}));
    send_bits(F1, 37, 0, 0, 0);
    check_result("after abort20", 23'h1, 16'h0, 1'b1, 8'd1);
    @(posedge clk);
    #1;
    check("abort20 out_valid count", 64'(ov_cnt - n0), 64'd1);
    check("abort20 abort count", 64'(ab_cnt - a0), 64'd1);
    n0 = ov_cnt;
    send_bits(FB, 38, 1, 1, 0);
    send_bits(F2, 38, 38, 1, 0);
    check("abort39 pulse", 64'({frame_abort, out_valid}), 64'({1'b1, 1'b0}));
    check("abort39 held", 64'({msg_out, syndrome, err_count}), 64'({23'h1, 16'h0, 8'd1}));
    send_bits(F2, 37, 0, 0, 0);
    check_result("after abort39", 23'h2, 16'h0, 1'b1, 8'd1);
    @(posedge clk);
    #1;
    check("abort39 out_valid count", 64'(ov_cnt - n0), 64'd1);
    send_bits(FB, 38, 9, 1, 0);
    n0 = ov_cnt;
    a0 = ab_cnt;
    rst_n = 0;
    @(posedge clk);
    #1;
    check("midframe reset outputs", 64'({msg_out, syndrome, crc_ok, out_valid, frame_abort, err_count}), 64'd0);
    rst_n = 1;
    send_bits(F2, 38, 0, 1, 0);
    check_result("after reset", 23'h2, 16'h0, 1'b1, 8'd0);
    @(posedge clk);
    #1;
    check("reset frame dropped", 64'({ov_cnt - n0, ab_cnt - a0}), 64'({32'd1, 32'd0}));
    for (int k = 1; k <= 300; k++) begin
      send_bits(FB, 38, 0, 1, 0);
      if (k == 100) check("err_count 100", 64'(err_count), 64'd100);
      if (k == 254) check("err_count 254", 64'(err_count), 64'd254);
      if (k == 255) check("err_count 255", 64'(err_count), 64'd255);
    end
    check_result("saturated", 23'h1, 16'h0001, 1'b0, 8'hFF);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
